aes_keyrevert128: RTL

//  AES-128 inverse key schedule for the decrypt path. Loads the round-10 key and walks the schedule backwards,

---
 rtl/aes_keyrevert128_if.sv | 25 ++
 rtl/aes_keyrevert128.sv | 137 +++++++++++++
 2 files changed

// File: rtl/aes_keyrevert128_if.sv
// Round-key walk bus for the AES-128 inverse key schedule.
// The master drives load/advance requests; the slave presents the current round key.
interface aes_keyrevert128_if;
   logic         ld;
   logic [127:0] KEY;
   logic         nxt;
   logic [31:0]  Wk0;
   logic [31:0]  Wk1;
   logic [31:0]  Wk2;
   logic [31:0]  Wk3;
   logic [3:0]   rnd;
   logic         kvld;
   logic         busy;
   logic         done;

   modport master (
      output ld, KEY, nxt,
      input  Wk0, Wk1, Wk2, Wk3, rnd, kvld, busy, done
   );

   modport slave (
      input  ld, KEY, nxt,
      output Wk0, Wk1, Wk2, Wk3, rnd, kvld, busy, done
   );
endinterface

// File: rtl/aes_keyrevert128.sv
// AES-128 inverse key schedule: loads the round-10 key and steps back one round per
// accepted advance, presenting round keys 10..0 for the inverse cipher.
module aes_keyrevert128 #(
   parameter bit AUTO_RUN = 1'b0
) (
   input logic              CLK,
   input logic              RST,
   aes_keyrevert128_if.slave bus
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   // Entry x lives at bits [8*(255-x) +: 8], i.e. table reads left to right from 0x00.
   localparam logic [2047:0] SboxTab = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      return SboxTab[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   logic [0:0]  state_q, state_d;
   logic [31:0] w0_q, w1_q, w2_q, w3_q;
   logic [31:0] w0_d, w1_d, w2_d, w3_d;
   logic [3:0]  rnd_q, rnd_d;
   logic        done_q, done_d;

   logic        step;
   logic [31:0] p0, p1, p2, p3;
   logic [31:0] rot_p3, sub_p3;

   assign step = AUTO_RUN ? 1'b1 : bus.nxt;

   // Previous-round words; p3 feeds the S-boxes straight from the current registers.
   always_comb begin
      p3     = w3_q ^ w2_q;
      p2     = w2_q ^ w1_q;
      p1     = w1_q ^ w0_q;
      rot_p3 = {p3[23:0], p3[31:24]};
      sub_p3 = {sub_byte(rot_p3[31:24]), sub_byte(rot_p3[23:16]),
                sub_byte(rot_p3[15:8]),  sub_byte(rot_p3[7:0])};
      p0     = w0_q ^ sub_p3 ^ {rcon_byte(rnd_q - 4'd1), 24'h000000};
   end

   always_comb begin
      state_d = state_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      w3_d    = w3_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      if (bus.ld) begin
         state_d = StRun;
         w0_d    = bus.KEY[127:96];
         w1_d    = bus.KEY[95:64];
         w2_d    = bus.KEY[63:32];
         w3_d    = bus.KEY[31:0];
         rnd_d   = 4'd10;
      end else if (state_q == StRun && step) begin
         if (rnd_q == 4'd0) begin
            state_d = StIdle;
            done_d  = 1'b1;
         end else begin
            w0_d  = p0;
            w1_d  = p1;
            w2_d  = p2;
            w3_d  = p3;
            rnd_d = rnd_q - 4'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         w0_q    <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         w3_q    <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         w3_q    <= w3_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   assign bus.Wk0  = w0_q;
   assign bus.Wk1  = w1_q;
   assign bus.Wk2  = w2_q;
   assign bus.Wk3  = w3_q;
   assign bus.rnd  = rnd_q;
   assign bus.kvld = (state_q == StRun);
   assign bus.busy = (state_q == StRun);
   assign bus.done = done_q;

endmodule
